fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
// - Shares the write port of asynchronous_fifo between NUM_REQ requesters in the wclk domain.
// - Round-robin arbitration at burst granularity; a granted requester keeps the port until its
//   last beat or MAX_BURST beats.
// - Drives write_enable/data_write straight into the FIFO; watches wfull and half_full.
// - Throttles new bursts once the FIFO reaches half full.
// PARAMETERS
// - NUM_REQ     4    number of requesters (2..16)
// - DATA_WIDTH  8    FIFO data width
// - MAX_BURST   16   max beats per grant (>=1); BCNT_W = $clog2(MAX_BURST+1)
// PORTS
// - wclk          in   1                   FIFO write clock; the only clock
// - wrst          in   1                   reset, synchronous, active-high
// - req_valid     in   NUM_REQ             per-requester beat valid
// - req_last      in   NUM_REQ             per-requester last beat of burst (qualified by valid)
// - req_data      in   NUM_REQ*DATA_WIDTH  beat data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
// - req_ready     out  NUM_REQ             per-requester beat accepted (comb)
// - wfull         in   1                   FIFO full flag
// - half_full     in   1                   FIFO half-full flag
// - write_enable  out  1                   FIFO write strobe (comb)
// - data_write    out  DATA_WIDTH          FIFO write data (comb)
// - gnt           out  NUM_REQ             one-hot current grant, registered
// - busy          out  1                   1 while in BURST
// - burst_cnt     out  BCNT_W              beats accepted in current burst, registered
// BEHAVIOUR
// - Reset (wrst sampled high at posedge wclk):
//   - state=IDLE, gnt=0, rr_ptr=0, burst_cnt=0.
//   - Comb outputs are therefore req_ready=0, write_enable=0.
//   - data_write=0 whenever gnt=0.
// - Reset asserted mid-burst abandons the burst; beats already written stay in the FIFO.
// - FSM states are IDLE and BURST.
// - IDLE, when (|req_valid) && !half_full && !wfull:
//   - Pick the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - Next cycle: gnt=1<<i, state=BURST, burst_cnt=0.
//   - No beat is accepted in IDLE, so grant-to-first-beat latency is 1 cycle.
// - IDLE with half_full or wfull high: no grant; state stays IDLE.
// - BURST with owner g:
//   - req_ready[g] = req_valid[g] & !wfull; all other req_ready bits are 0.
//   - write_enable = req_ready[g]; data_write = req_data[g] whenever gnt!=0.
//   - An accepted beat (write_enable=1) increments burst_cnt.
//   - Burst ends on an accepted beat with req_last[g]=1, or when burst_cnt+1 == MAX_BURST.
//   - On burst end: next state=IDLE, gnt=0, rr_ptr=(g+1) mod NUM_REQ, burst_cnt=0.
//   - Back-to-back bursts are therefore separated by exactly one IDLE cycle.
//   - half_full does not stall a burst already in progress; only wfull stalls beats.
//   - req_valid[g] low: the burst waits indefinitely (no timeout); gnt held.
// - wfull: write_enable is never 1 while wfull=1, matching the FIFO's own write guard. No overrun.
// - Requester handshake: once req_valid[i]=1, data/last are held until req_ready[i]=1.
// - Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
// - Width rules: burst_cnt saturates at MAX_BURST-1 before wrap; rr_ptr is $clog2(NUM_REQ) bits
//   and wraps explicitly at NUM_REQ (non-power-of-2 NUM_REQ supported).
// TESTING
// - Reset: wrst=1 for 2 cycles with req_valid=4'hF
//   -> gnt=0, write_enable=0, busy=0, burst_cnt=0 throughout.
// - Single burst: req0 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd)
//   -> gnt=0001 one cycle after req_valid.
//   -> 3 consecutive write_enable pulses with those data values.
//   -> gnt=0 the following cycle, rr_ptr=1.
// - Round-robin: all 4 valid, each sends 1-beat bursts
//   -> grant order 0,1,2,3,0.
//   -> each write_enable is 2 cycles apart (grant cycle + beat cycle).
// - MAX_BURST cut: req2 streams 20 beats with no last, MAX_BURST=16
//   -> 16 writes, then IDLE 1 cycle.
//   -> req3 (valid) granted next; req2 regranted only after req3, req0, req1.
// - Full stall: wfull=1 for 5 cycles during req1's burst
//   -> write_enable=0 and req_ready=0 for those 5 cycles; gnt held.
//   -> resumes with the same pending beat when wfull=0.
// - Throttle/reset: half_full=1 in IDLE with req_valid=4'h3
//   -> no grant until half_full=0.
//   -> wrst pulse during a burst at burst_cnt=5 -> next cycle gnt=0, burst_cnt=0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Shares the write port of an asynchronous FIFO between NUM_REQ requesters
// in the write-clock domain. Grants are round-robin and last for one burst:
// until the owner's last beat or MAX_BURST accepted beats, whichever is first.
// New bursts are held off while the FIFO is half full; beats stall on wfull.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int BCNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  input  logic                          half_full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         data_write,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          busy,
  output logic [BCNT_W-1:0]             burst_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic                  pick_found;
  logic [PTR_W-1:0]      pick_idx;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  accept;
  logic                  burst_end;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_REQ)) sum = sum - (PTR_W + 1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Select the current owner's valid/last/data; owner_q is only meaningful in BURST.
  always_comb begin
    owner_valid = req_valid[owner_q];
    owner_last  = req_last[owner_q];
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A beat is taken only in BURST, from the owner, and never while the FIFO is full.
  assign accept    = (state_q == BURST) && owner_valid && !wfull;
  assign burst_end = accept &&
                     (owner_last ||
                      (({1'b0, burst_cnt_q} + 1'b1) == (BCNT_W + 1)'(MAX_BURST)));

  // State register: synchronous reset abandons any burst in progress.
  always_ff @(posedge wclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (wrst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state logic: grant in IDLE, count and terminate bursts in BURST.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found && !half_full && !wfull) begin
          state_d     = BURST;
          gnt_d       = {{(NUM_REQ - 1){1'b0}}, 1'b1} << pick_idx;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_d     = IDLE;
          gnt_d       = '0;
          burst_cnt_d = '0;
          rr_ptr_d    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: steer the owner's beat straight into the FIFO write port.
  always_comb begin
    req_ready    = '0;
    write_enable = 1'b0;
    data_write   = '0;
    if (state_q == BURST) begin
      req_ready[owner_q] = accept;
      write_enable       = accept;
    end
    if (|gnt_q) data_write = owner_data;
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == BURST);
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int BW = $clog2(MB + 1);

  logic            wclk = 1'b0;
  logic            wrst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wfull;
  logic            half_full;
  logic            write_enable;
  logic [DW-1:0]   data_write;
  logic [N-1:0]    gnt;
  logic            busy;
  logic [BW-1:0]   burst_cnt;

  always #5 wclk = ~wclk;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst(wrst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .wfull(wfull), .half_full(half_full),
    .write_enable(write_enable), .data_write(data_write),
    .gnt(gnt), .busy(busy), .burst_cnt(burst_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Requester-side stimulus state: beats remaining, burst length, data base/sequence.
  int        rem [N];
  int        blen[N];
  int        gap [N];
  int        seq [N];
  logic [7:0] base[N];
  bit        nolast[N];
  bit        rnd_mode = 1'b0;

  // Reference model: owner (-1 when idle), round-robin pointer, beats in burst.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  // Observation logs taken from the DUT.
  int         gnt_log[$];
  int         wr_cyc[$];
  logic [7:0] wr_dat[$];
  logic [N-1:0] prev_gnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int qget_i(input int idx);
    return (idx < gnt_log.size()) ? gnt_log[idx] : -1;
  endfunction

  function automatic int wcyc(input int idx);
    return (idx < wr_cyc.size()) ? wr_cyc[idx] : -1;
  endfunction

  function automatic logic [7:0] wdat(input int idx);
    return (idx < wr_dat.size()) ? wr_dat[idx] : 8'hxx;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = (rem[i] > 0) && (gap[i] == 0);
      req_last[i]            = !nolast[i] && ((blen[i] == 1) || (rem[i] % blen[i] == 1));
      req_data[i*DW +: DW]   = base[i] + 8'(seq[i]);
    end
  endtask

  // One clock: drive, compare every output with the model, advance model and requesters.
  task automatic cycle();
    logic [N-1:0] e_rdy;
    logic [N-1:0] e_gnt;
    logic         e_we;
    logic [7:0]   e_dat;
    bit           found;
    apply();
    #1;
    e_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e_rdy = '0;
    if (m_owner >= 0 && req_valid[m_owner] && !wfull) e_rdy[m_owner] = 1'b1;
    e_we  = |e_rdy;
    e_dat = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : 8'h00;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("burst_cnt", 32'(burst_cnt), 32'(m_cnt));
    check("req_ready", 32'(req_ready), 32'(e_rdy));
    check("write_enable", 32'(write_enable), 32'(e_we));
    check("data_write", 32'(data_write), 32'(e_dat));
    if (gnt !== '0 && prev_gnt === '0) begin
      for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) gnt_log.push_back(i);
    end
    prev_gnt = gnt;
    if (write_enable === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(data_write);
    end
    if (wrst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      if (|req_valid && !half_full && !wfull) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1'b1; m_owner = (m_ptr + k) % N; m_cnt = 0;
          end
        end
      end
    end else if (e_we) begin
      if (req_last[m_owner] || (m_cnt + 1 == MB)) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (e_rdy[i]) begin
        rem[i]--; seq[i]++;
        if (rnd_mode && $urandom_range(0, 3) == 0) gap[i] = $urandom_range(1, 2);
      end else if (gap[i] > 0 && !req_valid[i]) begin
        gap[i]--;
      end
    end
    cyc++;
    @(negedge wclk);
  endtask

  task automatic clear_logs();
    gnt_log.delete(); wr_cyc.delete(); wr_dat.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; blen[i] = 1; gap[i] = 0; seq[i] = 0; base[i] = 8'(i * 16); nolast[i] = 1'b0;
    end
    wfull = 1'b0; half_full = 1'b0; wrst = 1'b1;
    cycle();
    wrst = 1'b0;
    clear_logs();
  endtask

  task automatic drain(input string tag, input int budget);
    int  n = 0;
    bit  pend;
    pend = 1'b1;
    while (pend && n < budget) begin
      pend = (m_owner >= 0);
      for (int i = 0; i < N; i++) if (rem[i] > 0) pend = 1'b1;
      if (pend) begin cycle(); n++; end
    end
    check(tag, 32'(pend), 32'd0);
  endtask

  task automatic run_until_cnt(input string tag, input int owner, input int cnt);
    int n = 0;
    while (!(m_owner == owner && m_cnt == cnt) && n < 40) begin cycle(); n++; end
    check(tag, 32'(m_owner == owner && m_cnt == cnt), 32'd1);
  endtask

  initial begin
    int start;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; blen[i] = 1; gap[i] = 0; seq[i] = 0; base[i] = '0; nolast[i] = 1'b0;
    end
    wrst = 1'b1; wfull = 1'b0; half_full = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    @(posedge wclk);
    @(negedge wclk);

    // Reset held two cycles with every requester asserting valid.
    for (int i = 0; i < N; i++) rem[i] = 1;
    cycle();
    cycle();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    do_reset();

    // Single 3-beat burst from requester 0.
    rem[0] = 3; blen[0] = 3; base[0] = 8'hA1;
    start = cyc;
    cycle();
    check("sb_gnt", 32'(gnt), 32'b0001);
    drain("sb_drain", 20);
    check("sb_nwr", 32'(wr_dat.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check("sb_data", 32'(wdat(k)), 32'(8'hA1 + k));
      check("sb_cyc", 32'(wcyc(k)), 32'(start + 1 + k));
    end
    check("sb_idle_gnt", 32'(gnt), 32'd0);
    clear_logs();
    rem[0] = 1; blen[0] = 1; rem[1] = 1; blen[1] = 1;
    drain("sb_ptr_drain", 20);
    check("sb_ptr_first", 32'(qget_i(0)), 32'd1);
    check("sb_ptr_second", 32'(qget_i(1)), 32'd0);

    // Round-robin with all requesters sending single-beat bursts.
    do_reset();
    for (int i = 0; i < N; i++) begin rem[i] = 2; blen[i] = 1; end
    drain("rr_drain", 60);
    check("rr_nwr", 32'(wr_cyc.size()), 32'd8);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(qget_i(k)), 32'(k % N));
    for (int k = 1; k < 8; k++) check("rr_spacing", 32'(wcyc(k) - wcyc(k - 1)), 32'd2);

    // MAX_BURST cut on a stream with no last beat.
    do_reset();
    rem[2] = 2 * MB; nolast[2] = 1'b1; base[2] = 8'h20;
    cycle();
    rem[0] = 1; rem[1] = 1; rem[3] = 1;
    drain("mb_drain", 200);
    check("mb_nwr", 32'(wr_cyc.size()), 32'(2 * MB + 3));
    check("mb_run", 32'(wcyc(MB - 1) - wcyc(0)), 32'(MB - 1));
    check("mb_last_data", 32'(wdat(MB - 1)), 32'(8'h20 + MB - 1));
    check("mb_gap", 32'(wcyc(MB) - wcyc(MB - 1)), 32'd2);
    check("mb_order0", 32'(qget_i(0)), 32'd2);
    check("mb_order1", 32'(qget_i(1)), 32'd3);
    check("mb_order2", 32'(qget_i(2)), 32'd0);
    check("mb_order3", 32'(qget_i(3)), 32'd1);
    check("mb_order4", 32'(qget_i(4)), 32'd2);

    // wfull stall during requester 1's burst.
    do_reset();
    rem[1] = 6; blen[1] = 6; base[1] = 8'h50;
    run_until_cnt("fs_reach", 1, 2);
    wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("fs_we", 32'(write_enable), 32'd0);
      check("fs_rdy", 32'(req_ready), 32'd0);
      check("fs_gnt", 32'(gnt), 32'b0010);
    end
    wfull = 1'b0;
    drain("fs_drain", 30);
    check("fs_nwr", 32'(wr_dat.size()), 32'd6);
    for (int k = 0; k < 6; k++) check("fs_data", 32'(wdat(k)), 32'(8'h50 + k));
    check("fs_resume", 32'(wcyc(2) - wcyc(1)), 32'd6);

    // half_full throttles new grants while idle.
    do_reset();
    half_full = 1'b1;
    rem[0] = 1; rem[1] = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("thr_gnt", 32'(gnt), 32'd0);
    end
    half_full = 1'b0;
    drain("thr_drain", 20);
    check("thr_order0", 32'(qget_i(0)), 32'd0);
    check("thr_order1", 32'(qget_i(1)), 32'd1);

    // Reset pulse in the middle of a burst.
    do_reset();
    rem[0] = 10; blen[0] = 10;
    run_until_cnt("mr_reach", 0, 5);
    check("mr_cnt_before", 32'(burst_cnt), 32'd5);
    wrst = 1'b1;
    cycle();
    wrst = 1'b0;
    check("mr_gnt", 32'(gnt), 32'd0);
    check("mr_cnt", 32'(burst_cnt), 32'd0);
    drain("mr_drain", 40);

    // Randomized traffic with random wfull/half_full pressure.
    do_reset();
    rnd_mode = 1'b1;
    for (int c = 0; c < 800; c++) begin
      wfull     = ($urandom_range(0, 9) == 0);
      half_full = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) begin
          blen[i] = $urandom_range(1, 20);
          rem[i]  = blen[i] * $urandom_range(1, 2);
          base[i] = 8'($urandom);
          seq[i]  = 0;
        end
      end
      cycle();
    end
    rnd_mode = 1'b0;
    wfull = 1'b0; half_full = 1'b0;
    drain("rnd_drain", 2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
